// File: rtl/psg_reg_decoder.sv
// SN76489-style register decoder snooping Z80 bus writes; holds tone periods and attenuations.
// Optional noise-channel registers are built when PSG_NOISE_EN is defined.
module psg_reg_decoder #(
    parameter logic [15:0] PSG_ADDR = 16'h007F,
    parameter int unsigned NUM_TONE = 3
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [15:0]              addr,
    input  logic                     MREQ_N,
    input  logic                     WR_N,
    input  logic [7:0]               data,
    output logic [NUM_TONE-1:0][9:0] freq,
    output logic [NUM_TONE-1:0][3:0] atten_mag,
    output logic [NUM_TONE-1:0]      enable,
    output logic [NUM_TONE-1:0]      atten_enable,
    output logic [NUM_TONE-1:0]      tone_upd,
`ifdef PSG_NOISE_EN
    output logic [2:0]               noise_ctrl,
    output logic [3:0]               noise_atten,
    output logic                     noise_rst,
`endif
    output logic [NUM_TONE-1:0]      atten_upd
);

    logic                     wr_now;
    logic                     wr_q;
    logic                     strobe;
    logic [NUM_TONE-1:0][9:0] freq_d, freq_q;
    logic [NUM_TONE-1:0][3:0] atten_d, atten_q;
    logic [1:0]               lat_ch_d, lat_ch_q;
    logic                     lat_type_d, lat_type_q;
    logic [NUM_TONE-1:0]      tone_upd_d, tone_upd_q;
    logic [NUM_TONE-1:0]      atten_upd_d, atten_upd_q;
    logic [1:0]               ch;
    logic                     is_atten;
`ifdef PSG_NOISE_EN
    logic [2:0]               noise_ctrl_d, noise_ctrl_q;
    logic [3:0]               noise_atten_d, noise_atten_q;
    logic                     noise_rst_d, noise_rst_q;
`endif

    assign wr_now = !MREQ_N && !WR_N && (addr == PSG_ADDR);
    // Rising edge of the qualified write, so a long write strobes exactly once.
    assign strobe = wr_now && !wr_q;

    always_comb begin
        freq_d      = freq_q;
        atten_d     = atten_q;
        lat_ch_d    = lat_ch_q;
        lat_type_d  = lat_type_q;
        tone_upd_d  = '0;
        atten_upd_d = '0;
        ch          = lat_ch_q;
        is_atten    = lat_type_q;
`ifdef PSG_NOISE_EN
        noise_ctrl_d  = noise_ctrl_q;
        noise_atten_d = noise_atten_q;
        noise_rst_d   = 1'b0;
`endif
        if (strobe) begin
            if (data[7]) begin
                ch         = data[6:5];
                is_atten   = data[4];
                lat_ch_d   = data[6:5];
                lat_type_d = data[4];
            end
            if (ch != 2'd3) begin
                if (is_atten) begin
                    atten_d[ch]     = data[3:0];
                    atten_upd_d[ch] = 1'b1;
                end else begin
                    if (data[7]) begin
                        freq_d[ch][3:0] = data[3:0];
                    end else begin
                        freq_d[ch][9:4] = data[5:0];
                    end
                    tone_upd_d[ch] = 1'b1;
                end
            end
`ifdef PSG_NOISE_EN
            else if (is_atten) begin
                noise_atten_d = data[3:0];
            end else begin
                noise_ctrl_d = data[2:0];
                noise_rst_d  = 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_q        <= 1'b0;
            freq_q      <= '0;
            atten_q     <= {NUM_TONE{4'hF}};
            lat_ch_q    <= 2'd0;
            lat_type_q  <= 1'b0;
            tone_upd_q  <= '0;
            atten_upd_q <= '0;
`ifdef PSG_NOISE_EN
            noise_ctrl_q  <= 3'd0;
            noise_atten_q <= 4'hF;
            noise_rst_q   <= 1'b0;
`endif
        end else begin
            wr_q        <= wr_now;
            freq_q      <= freq_d;
            atten_q     <= atten_d;
            lat_ch_q    <= lat_ch_d;
            lat_type_q  <= lat_type_d;
            tone_upd_q  <= tone_upd_d;
            atten_upd_q <= atten_upd_d;
`ifdef PSG_NOISE_EN
            noise_ctrl_q  <= noise_ctrl_d;
            noise_atten_q <= noise_atten_d;
            noise_rst_q   <= noise_rst_d;
`endif
        end
    end

    always_comb begin
        for (int i = 0; i < NUM_TONE; i++) begin
            enable[i]       = (freq_q[i] != 10'd0);
            atten_enable[i] = (atten_q[i] != 4'hF);
        end
    end

    assign freq      = freq_q;
    assign atten_mag = atten_q;
    assign tone_upd  = tone_upd_q;
    assign atten_upd = atten_upd_q;
`ifdef PSG_NOISE_EN
    assign noise_ctrl  = noise_ctrl_q;
    assign noise_atten = noise_atten_q;
    assign noise_rst   = noise_rst_q;
`endif

endmodule

// File: tb/tb_psg_reg_decoder.sv
// Randomized plus directed bench for psg_reg_decoder against a behavioural register model.
// Noise outputs are checked when PSG_NOISE_EN is defined.
module tb_psg_reg_decoder;

    logic             clk = 1'b0;
    logic             reset;
    logic [15:0]      addr;
    logic             MREQ_N;
    logic             WR_N;
    logic [7:0]       data;
    logic [2:0][9:0]  freq;
    logic [2:0][3:0]  atten_mag;
    logic [2:0]       enable;
    logic [2:0]       atten_enable;
    logic [2:0]       tone_upd;
    logic [2:0]       atten_upd;
`ifdef PSG_NOISE_EN
    logic [2:0]       noise_ctrl;
    logic [3:0]       noise_atten;
    logic             noise_rst;
`endif

    int checks   = 0;
    int failures = 0;

    // Behavioural model state
    int m_freq [3];
    int m_att  [3];
    int m_ch;
    int m_type;
    bit m_prev;
    bit m_tone_upd [3];
    bit m_att_upd  [3];
    int m_nctrl;
    int m_natt;
    bit m_nrst;

    psg_reg_decoder dut (
        .clk         (clk),
        .reset       (reset),
        .addr        (addr),
        .MREQ_N      (MREQ_N),
        .WR_N        (WR_N),
        .data        (data),
        .freq        (freq),
        .atten_mag   (atten_mag),
        .enable      (enable),
        .atten_enable(atten_enable),
        .tone_upd    (tone_upd),
`ifdef PSG_NOISE_EN
        .noise_ctrl  (noise_ctrl),
        .noise_atten (noise_atten),
        .noise_rst   (noise_rst),
`endif
        .atten_upd   (atten_upd)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_step(input bit rst, input bit mq, input bit wn,
                              input logic [15:0] a, input logic [7:0] d);
        bit active;
        int v;
        for (int i = 0; i < 3; i++) begin
            m_tone_upd[i] = 0;
            m_att_upd[i]  = 0;
        end
        m_nrst = 0;
        if (rst) begin
            for (int i = 0; i < 3; i++) begin
                m_freq[i] = 0;
                m_att[i]  = 15;
            end
            m_ch = 0; m_type = 0; m_prev = 0; m_nctrl = 0; m_natt = 15;
            return;
        end
        active = !mq && !wn && (a == 16'h007F);
        if (active && !m_prev) begin
            v = int'(d);
            if (v >= 128) begin
                m_ch   = (v / 32) % 4;
                m_type = (v / 16) % 2;
            end
            if (m_ch < 3) begin
                if (m_type == 1) begin
                    m_att[m_ch]     = v % 16;
                    m_att_upd[m_ch] = 1;
                end else begin
                    if (v >= 128) m_freq[m_ch] = (m_freq[m_ch] / 16) * 16 + v % 16;
                    else          m_freq[m_ch] = m_freq[m_ch] % 16 + (v % 64) * 16;
                    m_tone_upd[m_ch] = 1;
                end
            end else begin
`ifdef PSG_NOISE_EN
                if (m_type == 1) m_natt = v % 16;
                else begin
                    m_nctrl = v % 8;
                    m_nrst  = 1;
                end
`endif
            end
        end
        m_prev = active;
    endtask

    task automatic compare_all();
        logic [2:0] en_e, aen_e, tu_e, au_e;
        for (int i = 0; i < 3; i++) begin
            check($sformatf("freq%0d", i), 32'(freq[i]), m_freq[i]);
            check($sformatf("atten%0d", i), 32'(atten_mag[i]), m_att[i]);
            en_e[i]  = m_freq[i] != 0;
            aen_e[i] = m_att[i] != 15;
            tu_e[i]  = m_tone_upd[i];
            au_e[i]  = m_att_upd[i];
        end
        check("enable", 32'(enable), 32'(en_e));
        check("atten_enable", 32'(atten_enable), 32'(aen_e));
        check("tone_upd", 32'(tone_upd), 32'(tu_e));
        check("atten_upd", 32'(atten_upd), 32'(au_e));
`ifdef PSG_NOISE_EN
        check("noise_ctrl", 32'(noise_ctrl), m_nctrl);
        check("noise_atten", 32'(noise_atten), m_natt);
        check("noise_rst", 32'(noise_rst), 32'(m_nrst));
`endif
    endtask

    // One clock: drive, let the edge take it, then compare away from the edge.
    task automatic cyc(input bit rst, input bit mq, input bit wn,
                       input logic [15:0] a, input logic [7:0] d);
        reset = rst; MREQ_N = mq; WR_N = wn; addr = a; data = d;
        @(posedge clk);
        model_step(rst, mq, wn, a, d);
        #1;
        compare_all();
    endtask

    task automatic wr_byte(input logic [15:0] a, input logic [7:0] d, input int hold);
        for (int i = 0; i < hold; i++) cyc(0, 0, 0, a, d);
        cyc(0, 1, 1, a, d);
    endtask

    int pulses;

    initial begin
        reset = 1; MREQ_N = 1; WR_N = 1; addr = '0; data = '0;
        cyc(1, 1, 1, 16'h0000, 8'h00);
        cyc(1, 1, 1, 16'h0000, 8'h00);
        check("rst_freq", 32'(freq), 0);
        check("rst_atten", 32'(atten_mag), 32'hFFF);
        check("rst_flags", 32'({enable, atten_enable, tone_upd, atten_upd}), 0);
        cyc(0, 1, 1, 16'h0000, 8'h00);

        // Tone latch + data to channel 0, checking pulse timing directly
        cyc(0, 0, 0, 16'h007F, 8'h8E);
        check("tp_tu_first", 32'(tone_upd), 32'h1);
        cyc(0, 1, 1, 16'h007F, 8'h8E);
        check("tp_tu_gone", 32'(tone_upd), 32'h0);
        wr_byte(16'h007F, 8'h0F, 1);
        check("tp_freq0", 32'(freq[0]), 32'h0FE);
        check("tp_en0", 32'(enable[0]), 1);

        wr_byte(16'h007F, 8'hB5, 1);
        check("tp_att1", 32'(atten_mag[1]), 32'h5);
        check("tp_aen1", 32'(atten_enable[1]), 1);
        wr_byte(16'h007F, 8'h0F, 1);
        check("tp_att1_off", 32'(atten_mag[1]), 32'hF);
        check("tp_aen1_off", 32'(atten_enable[1]), 0);

        // Long write and foreign-address writes
        wr_byte(16'h0080, 8'h9A, 2);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            cyc(0, 0, 0, 16'h007F, 8'hC3);
            if (tone_upd[2]) pulses++;
        end
        cyc(0, 1, 1, 16'h007F, 8'hC3);
        check("tp_one_pulse", pulses, 1);
        check("tp_freq2", 32'(freq[2][3:0]), 32'h3);
        wr_byte(16'h0080, 8'h0A, 3);
        wr_byte(16'h0080, 8'hFF, 1);
        check("tp_freq2_kept", 32'(freq[2]), 32'h3);

        // Reset clears latch; repeated equal write still pulses
        wr_byte(16'h007F, 8'hA0, 1);
        cyc(1, 1, 1, 16'h0000, 8'h00);
        cyc(0, 1, 1, 16'h0000, 8'h00);
        wr_byte(16'h007F, 8'h12, 1);
        check("tp_freq0_rst", 32'(freq[0]), 32'h120);
        check("tp_freq1_rst", 32'(freq[1]), 0);
        cyc(0, 0, 0, 16'h007F, 8'h12);
        check("tp_same_pulse", 32'(tone_upd), 32'h1);
        cyc(0, 1, 1, 16'h007F, 8'h12);

        // Write held across reset release is accepted
        cyc(1, 0, 0, 16'h007F, 8'h97);
        cyc(0, 0, 0, 16'h007F, 8'h97);
        check("tp_rst_held", 32'(atten_upd), 32'h1);
        cyc(0, 1, 1, 16'h007F, 8'h00);

        // Channel 3 writes
        wr_byte(16'h007F, 8'hE5, 1);
        wr_byte(16'h007F, 8'hF2, 1);
`ifdef PSG_NOISE_EN
        check("tp_nctrl", 32'(noise_ctrl), 32'h5);
        check("tp_natt", 32'(noise_atten), 32'h2);
`endif
        wr_byte(16'h007F, 8'h3F, 1);

        for (int n = 0; n < 3000; n++) begin
            logic [15:0] a;
            a = ($urandom_range(0, 5) == 0) ? 16'($urandom) : 16'h007F;
            cyc($urandom_range(0, 99) < 2, $urandom_range(0, 3) == 0,
                $urandom_range(0, 3) == 0, a, 8'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/psg_reg_decoder.md
Name: psg_reg_decoder

Overview:
- Upstream front end of the PSG audio path: snoops Z80 bus write cycles and decodes SN76489-format latch/data bytes.
- Maintains per-channel tone period and attenuation registers.
- Drives the three tone synthesizers and attenuators with stable register values plus enable flags and one-cycle update pulses.

Parameters:
- PSG_ADDR, 16'h007F, bus address the PSG responds to (full 16-bit compare).
- NUM_TONE, 3, number of tone channels; fixed at 3, not to be overridden.

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- addr  input  16  Z80 address bus
- MREQ_N  input  1  memory request, active low
- WR_N  input  1  write strobe, active low
- data  input  8  Z80 data bus
- freq  output  [2:0][9:0]  tone period per channel
- atten_mag  output  [2:0][3:0]  attenuation per channel; 4'hF = silent
- enable  output  3  enable[i] = (freq[i] != 0)
- atten_enable  output  3  atten_enable[i] = (atten_mag[i] != 4'hF)
- tone_upd  output  3  one-cycle pulse when freq[i] is written
- atten_upd  output  3  one-cycle pulse when atten_mag[i] is written
- noise_ctrl  output  3  noise register; present only with PSG_NOISE_EN
- noise_atten  output  4  noise attenuation; present only with PSG_NOISE_EN
- noise_rst  output  1  one-cycle pulse on noise_ctrl write; present only with PSG_NOISE_EN

Behaviour:
- Bus write detect:
  - wr_now = !MREQ_N && !WR_N && (addr == PSG_ADDR); wr_q is wr_now registered.
  - strobe = wr_now && !wr_q, so exactly one strobe per bus write regardless of its length.
  - data is sampled in the strobe cycle only.
- Latch byte (data[7]=1):
  - lat_ch <= data[6:5], lat_type <= data[4] (1 = attenuation, 0 = tone).
  - If tone: freq[ch][3:0] <= data[3:0]; freq[ch][9:4] is unchanged.
  - If attenuation: atten_mag[ch] <= data[3:0].
- Data byte (data[7]=0), applied to the latched channel and type:
  - Tone: freq[lat_ch][9:4] <= data[5:0]; data[6] is ignored.
  - Attenuation: atten_mag[lat_ch] <= data[3:0].
  - The latch is not cleared, so repeated data bytes keep targeting the same register.
- Timing:
  - Register update and pulse assertion occur on the clk edge ending the strobe cycle; both are visible the cycle after the strobe.
  - tone_upd/atten_upd are high exactly one cycle, and pulse even when the written value equals the old value.
  - enable and atten_enable are combinational from the registered values, with the same latency.
- Channel 3 (lat_ch = 2'b11) is the noise channel; see Optional Feature.
- Reset (synchronous, has priority over strobe):
  - freq = 0, atten_mag = 4'hF, enable = 0, atten_enable = 0, all pulses 0.
  - lat_ch = 0, lat_type = 0, wr_q = 0.
  - noise_ctrl = 0, noise_atten = 4'hF.
- Reset released while a write is still held low: wr_q = 0 at release, so a strobe fires on the first post-reset cycle and that write is accepted. This is intended.
- Back-to-back writes: wr_now must deassert for at least one cycle between writes. A continuous low spanning two bus cycles counts as one write.
- Address mismatch or MREQ_N high: no strobe and no state change, including the latch.

Optional Feature:
- Macro: PSG_NOISE_EN.
- Defined:
  - Tone-type writes to channel 3 (latch or data byte) set noise_ctrl <= data[2:0] and pulse noise_rst one cycle.
  - Attenuation-type writes to channel 3 set noise_atten <= data[3:0].
- Undefined:
  - noise ports are absent.
  - Channel 3 writes still update lat_ch/lat_type but change no output and pulse nothing.

Test Plan:
- Reset asserted 2 cycles -> freq all 0, atten_mag all 4'hF, enable=3'b000, atten_enable=3'b000, no pulses.
- Write 8'h8E then 8'h0F to addr 16'h007F -> freq[0]=10'h0FE; tone_upd[0] pulses once per byte, each one cycle after its strobe; enable[0]=1.
- Write 8'hB5 -> atten_mag[1]=4'h5, atten_upd[1]=1 for one cycle, atten_enable[1]=1. Then write 8'h0F -> atten_mag[1]=4'hF, atten_enable[1]=0.
- Write 8'hC3 held low for 6 cycles, with addr 16'h0080 writes interleaved -> one tone_upd[2] pulse, freq[2][3:0]=4'h3; the 16'h0080 writes cause no change.
- Write 8'hA0 then reset mid-sequence, then 8'h12 -> after reset lat_ch=0 and lat_type=tone, so freq[0][9:4]=6'h12 and freq[1] stays 0.
- PSG_NOISE_EN defined: write 8'hE5 -> noise_ctrl=3'b101, noise_rst pulses one cycle. Then write 8'hF2 -> noise_atten=4'h2, and tone/atten outputs are unchanged.
